// File: rtl/rggen_rtl_pkg.sv
// rggen_rtl_pkg: shared register-bus protocol types
package rggen_rtl_pkg;
  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;
  typedef enum logic {
    RGGEN_READ  = 1'b0,
    RGGEN_WRITE = 1'b1
  } rggen_direction;
endpackage

// File: rtl/rggen_round_robin_selector.sv
// rggen_round_robin_selector: first asserted request scanning last+1, last+2, ... wrapping at WIDTH-1
//   request: per-requester request bits
//   last:    index of the requester served most recently
//   found:   any request asserted
//   index:   winning requester (0 when nothing is found)
module rggen_round_robin_selector #(
  parameter int WIDTH = 2,
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] request,
  input  logic [IW-1:0]    last,
  output logic             found,
  output logic [IW-1:0]    index
);
  int idx;
  always_comb begin
    found = |request;
    index = '0;
    idx   = 0;
    // scanned farthest-first so the nearest requester after last is written last and wins
    for (int i = WIDTH; i >= 1; i--) begin
      idx = (int'(last) + i >= WIDTH) ? int'(last) + i - WIDTH : int'(last) + i;
      if (request[IW'(idx)]) index = IW'(idx);
    end
  end
endmodule

// File: rtl/rggen_bus_arbiter.sv
// rggen_bus_arbiter: round-robin sharing of one downstream register bus between MASTERS upstream masters
//   m_*:         packed per-master request side; responses pulse only on the granted master's bits
//   s_*:         downstream bus, driven from the granted master while BUSY, zero while IDLE
//   grant_index: current or most recent grant
module rggen_bus_arbiter
  import rggen_rtl_pkg::*;
#(
  parameter int MASTERS       = 2,
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32,
  localparam int IW = $clog2(MASTERS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [MASTERS-1:0]              m_request,
  input  logic [MASTERS*ADDRESS_WIDTH-1:0] m_address,
  input  logic [MASTERS-1:0]              m_direction,
  input  logic [MASTERS*DATA_WIDTH-1:0]   m_write_data,
  input  logic [MASTERS*DATA_WIDTH/8-1:0] m_write_strobe,
  output logic [MASTERS-1:0]              m_done,
  output logic [MASTERS-1:0]              m_read_done,
  output logic [MASTERS-1:0]              m_write_done,
  output logic [DATA_WIDTH-1:0]           m_read_data,
  output logic [1:0]                      m_status,
  output logic                            s_request,
  output logic [ADDRESS_WIDTH-1:0]        s_address,
  output logic                            s_direction,
  output logic [DATA_WIDTH-1:0]           s_write_data,
  output logic [DATA_WIDTH/8-1:0]         s_write_strobe,
  input  logic                            s_done,
  input  logic                            s_read_done,
  input  logic                            s_write_done,
  input  logic [DATA_WIDTH-1:0]           s_read_data,
  input  logic [1:0]                      s_status,
  output logic [IW-1:0]                   grant_index
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [IW-1:0] grant, last, next;
  logic found, busy, done;
  logic [ADDRESS_WIDTH-1:0] addr [MASTERS];
  logic [DATA_WIDTH-1:0] wdata [MASTERS];
  logic [DATA_WIDTH/8-1:0] wstrb [MASTERS];
  for (genvar g = 0; g < MASTERS; g++) begin : g_slice
    assign addr[g]  = m_address[g*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign wdata[g] = m_write_data[g*DATA_WIDTH +: DATA_WIDTH];
    assign wstrb[g] = m_write_strobe[g*DATA_WIDTH/8 +: DATA_WIDTH/8];
  end
  rggen_round_robin_selector #(.WIDTH(MASTERS)) u_selector (
    .request (m_request),
    .last    (last),
    .found   (found),
    .index   (next)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      last  <= IW'(MASTERS - 1);
    end else if (state == IDLE && found) begin
      grant <= next;
      state <= BUSY;
    end else if (state == BUSY && s_done) begin
      last  <= grant;
      state <= IDLE;
    end
  end
  assign busy           = state == BUSY;
  assign done           = busy && s_done;
  assign s_request      = busy && m_request[grant];
  assign s_address      = busy ? addr[grant] : '0;
  assign s_direction    = busy && m_direction[grant];
  assign s_write_data   = busy ? wdata[grant] : '0;
  assign s_write_strobe = busy ? wstrb[grant] : '0;
  assign m_done         = done ? MASTERS'(1) << grant : '0;
  assign m_read_done    = done && s_read_done ? MASTERS'(1) << grant : '0;
  assign m_write_done   = done && s_write_done ? MASTERS'(1) << grant : '0;
  assign m_read_data    = done ? s_read_data : '0;
  assign m_status       = done ? s_status : RGGEN_OKAY;
  assign grant_index    = grant;
endmodule

// File: tb/tb_rggen_bus_arbiter.sv
// tb_rggen_bus_arbiter: randomized transactions on 2- and 3-master arbiters against a round-robin transaction model
module tb_rggen_bus_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] req = '0;
  logic [2:0][15:0] addr;
  logic [2:0] dir;
  logic [2:0][31:0] wd;
  logic [2:0][3:0] ws;
  logic s_done = 1'b0, s_read_done = 1'b0, s_write_done = 1'b0;
  logic [31:0] s_read_data = '0;
  logic [1:0] s_status = '0;
  logic [1:0] d2_done, d2_rdone, d2_wdone;
  logic [2:0] d3_done, d3_rdone, d3_wdone;
  logic [31:0] d2_rdata, d3_rdata, d2_swd, d3_swd;
  logic [1:0] d2_st, d3_st;
  logic d2_sreq, d3_sreq, d2_sdir, d3_sdir;
  logic [15:0] d2_sa, d3_sa;
  logic [3:0] d2_sws, d3_sws;
  logic d2_gi;
  logic [1:0] d3_gi;
  logic sel = 1'b0;
  int m = 2;
  int mlast = 1;
  int pg = 0;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  rggen_bus_arbiter #(.MASTERS(2), .ADDRESS_WIDTH(16), .DATA_WIDTH(32)) dut2 (
    .clk(clk), .rst_n(rst_n), .m_request(req[1:0]), .m_address(addr[1:0]), .m_direction(dir[1:0]),
    .m_write_data(wd[1:0]), .m_write_strobe(ws[1:0]), .m_done(d2_done), .m_read_done(d2_rdone),
    .m_write_done(d2_wdone), .m_read_data(d2_rdata), .m_status(d2_st), .s_request(d2_sreq),
    .s_address(d2_sa), .s_direction(d2_sdir), .s_write_data(d2_swd), .s_write_strobe(d2_sws),
    .s_done(s_done), .s_read_done(s_read_done), .s_write_done(s_write_done),
    .s_read_data(s_read_data), .s_status(s_status), .grant_index(d2_gi)
  );
  rggen_bus_arbiter #(.MASTERS(3), .ADDRESS_WIDTH(16), .DATA_WIDTH(32)) dut3 (
    .clk(clk), .rst_n(rst_n), .m_request(req), .m_address(addr), .m_direction(dir),
    .m_write_data(wd), .m_write_strobe(ws), .m_done(d3_done), .m_read_done(d3_rdone),
    .m_write_done(d3_wdone), .m_read_data(d3_rdata), .m_status(d3_st), .s_request(d3_sreq),
    .s_address(d3_sa), .s_direction(d3_sdir), .s_write_data(d3_swd), .s_write_strobe(d3_sws),
    .s_done(s_done), .s_read_done(s_read_done), .s_write_done(s_write_done),
    .s_read_data(s_read_data), .s_status(s_status), .grant_index(d3_gi)
  );
  logic [2:0] o_done, o_rdone, o_wdone;
  logic [31:0] o_rdata, o_swd;
  logic [1:0] o_st, o_gi;
  logic o_sreq, o_sdir;
  logic [15:0] o_sa;
  logic [3:0] o_sws;
  assign o_done  = sel ? d3_done  : {1'b0, d2_done};
  assign o_rdone = sel ? d3_rdone : {1'b0, d2_rdone};
  assign o_wdone = sel ? d3_wdone : {1'b0, d2_wdone};
  assign o_rdata = sel ? d3_rdata : d2_rdata;
  assign o_st    = sel ? d3_st    : d2_st;
  assign o_sreq  = sel ? d3_sreq  : d2_sreq;
  assign o_sdir  = sel ? d3_sdir  : d2_sdir;
  assign o_sa    = sel ? d3_sa    : d2_sa;
  assign o_swd   = sel ? d3_swd   : d2_swd;
  assign o_sws   = sel ? d3_sws   : d2_sws;
  assign o_gi    = sel ? d3_gi    : {1'b0, d2_gi};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s (M=%0d) got %h expected %h at %0t", tag, m, got, exp, $time);
    end
  endtask
  function automatic int rr(input logic [2:0] r, input int last, input int n);
    for (int k = 1; k <= n; k++)
      if (r[(last + k) % n]) return (last + k) % n;
    return -1;
  endfunction
  task automatic idle_chk();
    chk("idle_s_request", 32'(o_sreq), 0);
    chk("idle_s_address", 32'(o_sa), 0);
    chk("idle_m_done", 32'(o_done), 0);
    chk("idle_m_read_data", o_rdata, 0);
    chk("idle_m_status", 32'(o_st), 0);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    s_done = 0; s_read_done = 0; s_write_done = 0;
    repeat (2) @(negedge clk);
    #1;
    idle_chk();
    chk("reset_grant_index", 32'(o_gi), 0);
    rst_n = 1'b1;
    mlast = m - 1;
  endtask
  task automatic run_txn(input int lat, input bit abort, input logic [31:0] rdata, input logic [1:0] st);
    int g;
    logic [2:0] oh;
    bit fin;
    g = rr(req, mlast, m);
    oh = 3'b001 << g;
    #1;
    idle_chk();
    for (int c = 0; c < lat; c++) begin
      @(negedge clk);
      req[g] = !(abort && c == 0);
      fin = c == lat - 1;
      s_done = fin;
      s_read_done = fin && !dir[g];
      s_write_done = fin && dir[g];
      s_read_data = fin ? rdata : $urandom;
      s_status = fin ? st : 2'($urandom);
      #1;
      chk("s_request", 32'(o_sreq), 32'(req[g]));
      chk("s_address", 32'(o_sa), 32'(addr[g]));
      chk("s_direction", 32'(o_sdir), 32'(dir[g]));
      chk("s_write_data", o_swd, wd[g]);
      chk("s_write_strobe", 32'(o_sws), 32'(ws[g]));
      chk("grant_index", 32'(o_gi), 32'(g));
      chk("m_done", 32'(o_done), fin ? 32'(oh) : 0);
      chk("m_read_done", 32'(o_rdone), fin && !dir[g] ? 32'(oh) : 0);
      chk("m_write_done", 32'(o_wdone), fin && dir[g] ? 32'(oh) : 0);
      chk("m_read_data", o_rdata, fin ? rdata : 0);
      chk("m_status", 32'(o_st), fin ? 32'(st) : 0);
    end
    @(negedge clk);
    s_done = 0; s_read_done = 0; s_write_done = 0;
    mlast = g;
    pg = g;
  endtask
  task automatic rand_req();
    for (int i = 0; i < m; i++)
      if (i == pg || !req[i]) begin
        req[i] = 1'($urandom);
        addr[i] = 16'($urandom);
        dir[i] = 1'($urandom);
        wd[i] = $urandom;
        ws[i] = 4'($urandom);
      end
    if ((req & (sel ? 3'b111 : 3'b011)) == 0) req[$urandom_range(0, m - 1)] = 1'b1;
  endtask
  task automatic rand_phase(input int n);
    int lat;
    repeat (n) begin
      rand_req();
      lat = $urandom_range(1, 3);
      run_txn(lat, lat > 1 && $urandom_range(0, 3) == 0, $urandom, 2'($urandom));
    end
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      addr[i] = 16'($urandom); dir[i] = 1'($urandom); wd[i] = $urandom; ws[i] = 4'($urandom);
    end
    sel = 1'b0; m = 2;
    do_reset();
    req = 3'b001; addr[0] = 16'h0010; dir[0] = 1'b1; wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    run_txn(1, 0, $urandom, 2'd0);
    req = 3'b011;
    repeat (4) run_txn(2, 0, $urandom, 2'd0);
    req = 3'b010; dir[1] = 1'b0;
    run_txn(2, 0, 32'h12345678, 2'd2);
    req = 3'b000;
    s_done = 1; s_read_done = 1;
    #1;
    idle_chk();
    @(negedge clk);
    s_done = 0; s_read_done = 0;
    #1;
    chk("idle_after_stray_done", 32'(o_sreq), 0);
    req = 3'b011;
    #1;
    @(negedge clk);
    #1;
    chk("busy_before_reset", 32'(o_sreq), 1);
    rst_n = 1'b0;
    s_done = 1; s_write_done = 1; s_read_done = 1;
    #1;
    chk("reset_s_request", 32'(o_sreq), 0);
    chk("reset_m_done", 32'(o_done), 0);
    chk("reset_m_write_done", 32'(o_wdone), 0);
    chk("reset_m_read_done", 32'(o_rdone), 0);
    @(negedge clk);
    rst_n = 1'b1;
    s_done = 0; s_write_done = 0; s_read_done = 0;
    mlast = m - 1;
    run_txn(1, 0, $urandom, 2'd0);
    rand_phase(150);
    sel = 1'b1; m = 3;
    do_reset();
    req = 3'b111;
    repeat (5) run_txn(1, 0, $urandom, 2'd0);
    rand_phase(150);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rggen_bus_arbiter.md
Name: rggen_bus_arbiter

Overview:
- Shares one downstream register bus, the slave-side bus feeding the register splitter, between N upstream bus masters.
- Example masters: host adapter, debug port, DMA.
- Round-robin grant, one transaction in flight, responses routed back only to the granted master.
- Sits between the host-protocol adapters and the bus splitter; the downstream side uses the same request/done/read_done/write_done/read_data/status protocol.

Parameters:
- MASTERS, 2, number of upstream requesters (>=2).
- ADDRESS_WIDTH, 16, byte address width.
- DATA_WIDTH, 32, data/strobe width (strobe = DATA_WIDTH/8).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- m_request  in  MASTERS  per-master request, held until that master's done
- m_address  in  MASTERS*ADDRESS_WIDTH  packed per-master address
- m_direction  in  MASTERS  per-master rggen_direction (0 read, 1 write)
- m_write_data  in  MASTERS*DATA_WIDTH  per-master write data
- m_write_strobe  in  MASTERS*DATA_WIDTH/8  per-master byte strobe
- m_done  out  MASTERS  per-master done pulse
- m_read_done  out  MASTERS  per-master read-done pulse
- m_write_done  out  MASTERS  per-master write-done pulse
- m_read_data  out  DATA_WIDTH  read data, valid with m_read_done of granted master
- m_status  out  2  rggen_status, valid with m_done
- s_request  out  1  downstream request
- s_address  out  ADDRESS_WIDTH  downstream address
- s_direction  out  1  downstream direction
- s_write_data  out  DATA_WIDTH  downstream write data
- s_write_strobe  out  DATA_WIDTH/8  downstream strobe
- s_done  in  1  downstream done pulse
- s_read_done  in  1  downstream read done
- s_write_done  in  1  downstream write done
- s_read_data  in  DATA_WIDTH  downstream read data
- s_status  in  2  downstream status
- grant_index  out  $clog2(MASTERS)  current/last granted master (debug)

Behaviour:
- States: IDLE, BUSY.
- Registers: state, grant (index), last (index of last completed grant).
- Reset values:
  - state=IDLE, grant=0, last=MASTERS-1, so master 0 wins first.
  - All outputs 0: s_request=0, m_done/m_read_done/m_write_done=0, m_read_data=0, m_status=RGGEN_OKAY(0).
- Arbitration (IDLE, |m_request):
  - Pick the first requesting index scanning last+1, last+2, ... mod MASTERS.
  - Register it into grant; state to BUSY.
  - Priority among simultaneous requests comes solely from this scan.
- Latency: grant is registered, so s_request rises 1 cycle after the arbitrating cycle. Minimum master request-to-done is 1 arbitration cycle plus downstream latency.
- BUSY datapath:
  - s_request = m_request[grant].
  - s_address, s_direction, s_write_data and s_write_strobe are combinational slices of master grant.
  - In IDLE, s_request=0 and the other s_* outputs are 0.
- Response routing (combinational, no added latency):
  - m_done[grant]=s_done&BUSY; same for read_done and write_done. All other bits are 0.
  - m_read_data/m_status pass through from s_* while BUSY&s_done; otherwise 0/OKAY.
- Completion: on s_done in BUSY, last<=grant and state<=IDLE. The next arbitration happens in the following cycle.
  - Because of this, a master re-requesting immediately does not get back-to-back grants while others wait.
- Single requester: repeated transactions alternate between the IDLE (arbitration) and BUSY phases. Throughput is one transaction per (downstream latency + 1) cycles.
- Protocol violation, m_request[grant] dropped in BUSY before s_done:
  - s_request follows it low, forming an abort.
  - The arbiter stays BUSY until m_request[grant] reasserts or s_done arrives. No timeout.
- s_done while IDLE: ignored; no m_done bit asserts.
- Asynchronous reset mid-transaction: immediately IDLE and s_request=0. The in-flight transaction is dropped and the downstream splitter sees its request removed.
- MASTERS not a power of two: the scan wraps at MASTERS-1, never at 2^k.

Decomposition:
- Use rggen_rtl_pkg for rggen_status and rggen_direction (RGGEN_READ/RGGEN_WRITE, RGGEN_OKAY, RGGEN_SLAVE_ERROR). No new package types.
- One sub-module: rggen_round_robin_selector.
  - Combinational.
  - Params: WIDTH.
  - Inputs: request[WIDTH], last index.
  - Outputs: found, index.
  - Reused by later multi-host blocks.

Test Plan:
- After reset, m_request=2'b01, write addr 0x0010 data 0xDEADBEEF strobe 0xF:
  - s_request rises 1 cycle later with matching fields.
  - Downstream s_done+s_write_done gives m_done[0] and m_write_done[0] in the same cycle.
  - m_done[1]=0.
- m_request=2'b11 held continuously, 4 transactions:
  - Grant order is 0,1,0,1.
  - Each m_done asserts only on the granted bit.
  - grant_index tracks the grant.
- MASTERS=3, all requesting, last=1 (master 1 was the last to complete):
  - Next grant is 2, then 0, then 1.
- Read from master 1 with s_read_data=0x12345678, s_status=RGGEN_SLAVE_ERROR:
  - m_read_done[1]=1, m_read_data=0x12345678, m_status=2 for exactly 1 cycle.
  - 0/OKAY afterwards.
- rst_n asserted while BUSY:
  - s_request and all m_done bits go 0 immediately.
  - After release, master 0 wins the first contention against master 1.
- s_done pulse injected while IDLE with no requests: all m_done bits stay 0 and state stays IDLE.
